// File: rtl/fft_pkg.sv
// Shared constants for the 32-point radix-2 SDF FFT pipeline: widths, butterfly
// state encodings, stage phase encodings and the phase sequencing helper.
package fft_pkg;

  localparam int DW       = 19;
  localparam int TW       = 9;
  localparam int N_FFT    = 32;
  localparam int TW_SHIFT = 8;

  localparam logic [1:0] BF_IDLE    = 2'b00;
  localparam logic [1:0] BF_FIRST   = 2'b01;
  localparam logic [1:0] BF_SECOND  = 2'b10;
  localparam logic [1:0] BF_WAITING = 2'b11;

  localparam logic [1:0] FILL    = 2'd0;
  localparam logic [1:0] COMBINE = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;

  function automatic logic [1:0] next_phase(input logic [1:0] p);
    case (p)
      FILL:    return COMBINE;
      COMBINE: return DRAIN;
      default: return FILL;
    endcase
  endfunction

endpackage

// File: rtl/sdf_r2_stage_if.sv
// Sample-stream bundle of one SDF stage: upstream valid/ready/data plus the
// registered downstream output and the busy flag.
interface sdf_r2_stage_if #(parameter int DW = fft_pkg::DW);

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic signed [DW-1:0] din_r;
  logic signed [DW-1:0] din_i;
  logic                 out_valid_o;
  logic signed [DW-1:0] dout_r;
  logic signed [DW-1:0] dout_i;
  logic                 busy_o;

  modport master (
    output in_valid_i, din_r, din_i,
    input  in_ready_o, out_valid_o, dout_r, dout_i, busy_o
  );

  modport slave (
    input  in_valid_i, din_r, din_i,
    output in_ready_o, out_valid_o, dout_r, dout_i, busy_o
  );

endinterface

// File: rtl/twiddle_rom.sv
// Twiddle factors W32^k for k = 0..15, scaled by 2^8 and clamped to the signed
// 9-bit range, so W^0 reads (255, 0) and W^8 reads (0, -256).
module twiddle_rom #(
  parameter int TW = fft_pkg::TW
) (
  input  logic [3:0]           k,
  output logic signed [TW-1:0] wn_r,
  output logic signed [TW-1:0] wn_i
);

  localparam int COS_T [16] = '{255, 251, 237, 213, 181, 142,  98,  50,
                                  0, -50, -98, -142, -181, -213, -237, -251};
  localparam int SIN_T [16] = '{0, -50, -98, -142, -181, -213, -237, -251,
                                -256, -251, -237, -213, -181, -142, -98, -50};

  always_comb begin
    wn_r = TW'(COS_T[k]);
    wn_i = TW'(SIN_T[k]);
  end

endmodule

// File: rtl/sdf_r2_stage.sv
// Sequential shell of one radix-2 SDF stage: delay line, phase/sample counter,
// twiddle addressing and output register around an external butterfly.
// Optional macro SDF_UNITY_BYPASS_EN: DRAIN cycles with k=0 forward the head directly.
module sdf_r2_stage #(
  parameter int DEPTH = 16,
  parameter int DW    = fft_pkg::DW,
  parameter int TW    = fft_pkg::TW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdf_r2_stage_if.slave        io,
  output logic [1:0]           bf_state_o,
  output logic signed [DW-1:0] bf_A_r,
  output logic signed [DW-1:0] bf_A_i,
  output logic signed [DW-1:0] bf_B_r,
  output logic signed [DW-1:0] bf_B_i,
  output logic signed [TW-1:0] bf_WN_r,
  output logic signed [TW-1:0] bf_WN_i,
  input  logic signed [DW-1:0] bf_out_r,
  input  logic signed [DW-1:0] bf_out_i,
  input  logic signed [DW-1:0] bf_SR_r,
  input  logic signed [DW-1:0] bf_SR_i
);

  import fft_pkg::*;

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int STRIDE = 16 / DEPTH;

  logic [1:0]           phase;
  logic [CW-1:0]        cnt;
  logic signed [DW-1:0] dl_r [DEPTH];
  logic signed [DW-1:0] dl_i [DEPTH];
  logic signed [DW-1:0] head_r, head_i;
  logic signed [DW-1:0] shift_r, shift_i;
  logic signed [TW-1:0] rom_r, rom_i;
  logic [3:0]           k_idx;
  logic                 accept, advance, sample_out, last, use_head;

  assign head_r = dl_r[DEPTH-1];
  assign head_i = dl_i[DEPTH-1];

  assign io.in_ready_o = (phase != DRAIN);
  assign io.busy_o     = (phase != FILL) || (cnt != '0);
  assign accept        = io.in_valid_i & io.in_ready_o;
  assign last          = (cnt == CW'(DEPTH - 1));
  assign k_idx         = 4'(int'(cnt) * STRIDE);

  twiddle_rom #(.TW(TW)) u_rom (
    .k    (k_idx),
    .wn_r (rom_r),
    .wn_i (rom_i)
  );

  assign bf_WN_r = (phase == DRAIN) ? rom_r : '0;
  assign bf_WN_i = (phase == DRAIN) ? rom_i : '0;

`ifdef SDF_UNITY_BYPASS_EN
  assign use_head = (phase == DRAIN) && (k_idx == 4'd0);
`else
  assign use_head = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    bf_state_o = BF_IDLE;
    bf_A_r     = '0;
    bf_A_i     = '0;
    bf_B_r     = '0;
    bf_B_i     = '0;
    shift_r    = '0;
    shift_i    = '0;
    advance    = 1'b0;
    sample_out = 1'b0;
    case (phase)
      FILL: if (accept) begin
        bf_state_o = BF_WAITING;
        bf_A_r     = io.din_r;
        bf_A_i     = io.din_i;
        shift_r    = bf_SR_r;
        shift_i    = bf_SR_i;
        advance    = 1'b1;
      end
      COMBINE: if (accept) begin
        bf_state_o = BF_FIRST;
        bf_A_r     = head_r;
        bf_A_i     = head_i;
        bf_B_r     = io.din_r;
        bf_B_i     = io.din_i;
        shift_r    = bf_SR_r;
        shift_i    = bf_SR_i;
        advance    = 1'b1;
        sample_out = 1'b1;
      end
      DRAIN: begin
        bf_state_o = BF_SECOND;
        bf_B_r     = head_r;
        bf_B_i     = head_i;
        advance    = 1'b1;
        sample_out = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: the delay line is reset explicitly because an aborted frame must leave no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        dl_r[j] <= '0;
        dl_i[j] <= '0;
      end
    end else if (advance) begin
      dl_r[0] <= shift_r;
      dl_i[0] <= shift_i;
      for (int j = 1; j < DEPTH; j++) begin
        dl_r[j] <= dl_r[j-1];
        dl_i[j] <= dl_i[j-1];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase          <= FILL;
      cnt            <= '0;
      io.out_valid_o <= 1'b0;
      io.dout_r      <= '0;
      io.dout_i      <= '0;
    end else begin
      if (advance) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) phase <= next_phase(phase);
      end
      io.out_valid_o <= sample_out;
      if (sample_out) begin
        io.dout_r <= use_head ? head_r : bf_out_r;
        io.dout_i <= use_head ? head_i : bf_out_i;
      end
    end
  end

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Scoreboard bench for sdf_r2_stage at DEPTH 2, 16, 4 and 1 with a behavioural
// radix-2 butterfly; expected outputs come from a frame-level arithmetic model.
module tb_sdf_r2_stage;

  import fft_pkg::*;

  localparam int NI = 4;
  localparam int WR [16] = '{255, 251, 237, 213, 181, 142,  98,  50,
                               0, -50, -98, -142, -181, -213, -237, -251};
  localparam int WI [16] = '{0, -50, -98, -142, -181, -213, -237, -251,
                             -256, -251, -237, -213, -181, -142, -98, -50};
`ifdef SDF_UNITY_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic signed [18:0] r;
    logic signed [18:0] i;
  } samp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               in_valid [NI];
  logic signed [18:0] din_r [NI], din_i [NI];
  logic               ir [NI], ov [NI], busy [NI];
  logic [1:0]         bs [NI];
  logic signed [18:0] dr [NI], di [NI];

  int    n_tests = 0;
  int    n_fail  = 0;
  int    low_cnt = 0;
  samp_t exp_q [$];
  samp_t mon_e;
  logic signed [18:0] fr_r [32], fr_i [32];

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int D = (g == 0) ? 2 : (g == 1) ? 16 : (g == 2) ? 4 : 1;
    sdf_r2_stage_if #(.DW(19)) ifc ();
    logic [1:0]         st;
    logic signed [18:0] ar, ai, br, bi, outr, outi, srr, sri;
    logic signed [8:0]  wr, wi;

    sdf_r2_stage #(.DEPTH(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io         (ifc),
      .bf_state_o (st),
      .bf_A_r     (ar),
      .bf_A_i     (ai),
      .bf_B_r     (br),
      .bf_B_i     (bi),
      .bf_WN_r    (wr),
      .bf_WN_i    (wi),
      .bf_out_r   (outr),
      .bf_out_i   (outi),
      .bf_SR_r    (srr),
      .bf_SR_i    (sri)
    );

    assign ifc.in_valid_i = in_valid[g];
    assign ifc.din_r      = din_r[g];
    assign ifc.din_i      = din_i[g];
    assign ir[g]          = ifc.in_ready_o;
    assign ov[g]          = ifc.out_valid_o;
    assign busy[g]        = ifc.busy_o;
    assign dr[g]          = ifc.dout_r;
    assign di[g]          = ifc.dout_i;
    assign bs[g]          = st;

    always_comb begin : butterfly
      int pr;
      int pi;
      pr   = int'(br) * int'(wr) - int'(bi) * int'(wi);
      pi   = int'(br) * int'(wi) + int'(bi) * int'(wr);
      outr = '0;
      outi = '0;
      srr  = '0;
      sri  = '0;
      case (st)
        BF_FIRST: begin
          outr = ar + br;
          outi = ai + bi;
          srr  = ar - br;
          sri  = ai - bi;
        end
        BF_WAITING: begin
          srr = ar;
          sri = ai;
        end
        BF_SECOND: begin
          outr = pr[26:8];
          outi = pi[26:8];
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected stage output for the frame held in fr_*, at most lim entries.
  task automatic push_frame(input int d, input int lim);
    samp_t e;
    logic signed [18:0] xr, xi;
    int pr, pi, k, n_pushed;
    n_pushed = 0;
    for (int n = 0; n < d && n_pushed < lim; n++) begin
      e.r = fr_r[n] + fr_r[n+d];
      e.i = fr_i[n] + fr_i[n+d];
      exp_q.push_back(e);
      n_pushed++;
    end
    for (int n = 0; n < d && n_pushed < lim; n++) begin
      xr = fr_r[n] - fr_r[n+d];
      xi = fr_i[n] - fr_i[n+d];
      k  = n * (16 / d);
      pr = int'(xr) * WR[k] - int'(xi) * WI[k];
      pi = int'(xr) * WI[k] + int'(xi) * WR[k];
      if (BYPASS && k == 0) begin
        e.r = xr;
        e.i = xi;
      end else begin
        e.r = 19'(pr >>> 8);
        e.i = 19'(pi >>> 8);
      end
      exp_q.push_back(e);
      n_pushed++;
    end
  endtask

  task automatic drive(input int g, input int nsamp, input bit gap);
    int guard;
    for (int s = 0; s < nsamp; s++) begin
      if (gap && s > 0) begin
        @(negedge clk);
        in_valid[g] = 1'b0;
        #1;
        if (ir[g]) check("gap_bf_state_idle", bs[g], BF_IDLE);
      end
      @(negedge clk);
      in_valid[g] = 1'b1;
      din_r[g]    = fr_r[s];
      din_i[g]    = fr_i[s];
      guard       = 0;
      while (!ir[g] && guard <= 100) begin
        guard++;
        @(negedge clk);
      end
      if (guard > 100) check("ready_timeout", guard, 0);
    end
    @(negedge clk);
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_frame();
    for (int n = 0; n < 32; n++) begin
      fr_r[n] = '0;
      fr_i[n] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (!ir[0]) low_cnt++;
    for (int g = 0; g < NI; g++) begin
      if (ov[g]) begin
        check("output_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check($sformatf("dout_r[%0d]", g), dr[g], mon_e.r);
          check($sformatf("dout_i[%0d]", g), di[g], mon_e.i);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      in_valid[g] = 1'b0;
      din_r[g]    = '0;
      din_i[g]    = '0;
    end
    #12;
    for (int g = 0; g < NI; g++) begin
      check("rst_dout_r", dr[g], 0);
      check("rst_out_valid", ov[g], 0);
      check("rst_busy", busy[g], 0);
      check("rst_in_ready", ir[g], 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NI; g++) check("post_rst_bf_idle", bs[g], BF_IDLE);

    // DEPTH=2, continuous real ramp
    clear_frame();
    fr_r[0] = 256; fr_r[1] = 512; fr_r[2] = 768; fr_r[3] = 1024;
    push_frame(2, 4);
    low_cnt = 0;
    drive(0, 4, 1'b0);
    wait_drain();
    check("d2_ready_low_cycles", low_cnt, 2);
    check("d2_idle_busy", busy[0], 0);

    // DEPTH=2, same data with a gap before every sample
    push_frame(2, 4);
    drive(0, 4, 1'b1);
    wait_drain();

    // DEPTH=16: constant first half gives differences of 256 -> 256*W^n
    clear_frame();
    for (int n = 0; n < 16; n++) fr_r[n] = 256;
    push_frame(16, 32);
    drive(1, 32, 1'b0);
    wait_drain();

    // DEPTH=16 impulse frame
    clear_frame();
    fr_r[0] = 256;
    push_frame(16, 32);
    drive(1, 32, 1'b0);
    wait_drain();

    // DEPTH=16 complex ramp exercising the imaginary paths
    for (int n = 0; n < 32; n++) begin
      fr_r[n] = 19'(n * 37 - 200);
      fr_i[n] = 19'(300 - n * 11);
    end
    push_frame(16, 32);
    drive(1, 32, 1'b0);
    wait_drain();

    // DEPTH=4: reset two samples into COMBINE
    clear_frame();
    for (int n = 0; n < 8; n++) begin
      fr_r[n] = 19'(n * 50 + 10);
      fr_i[n] = 19'(-n * 20);
    end
    push_frame(4, 2);
    drive(2, 6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dout_r", dr[2], 0);
    check("midrst_dout_i", di[2], 0);
    check("midrst_out_valid", ov[2], 0);
    check("midrst_busy", busy[2], 0);
    check("midrst_in_ready", ir[2], 1);
    @(negedge clk);
    check("midrst_queue_empty", exp_q.size(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_idle", bs[2], BF_IDLE);
    for (int n = 0; n < 8; n++) begin
      fr_r[n] = 19'(1000 - n * 90);
      fr_i[n] = 19'(n * 33);
    end
    push_frame(4, 8);
    drive(2, 8, 1'b0);
    wait_drain();

    // DEPTH=1: three back-to-back frames
    clear_frame();
    for (int n = 0; n < 6; n += 2) begin
      fr_r[n]   = 100; fr_i[n]   = -50;
      fr_r[n+1] = 20;  fr_i[n+1] = 30;
    end
    for (int f = 0; f < 3; f++) push_frame(1, 2);
    drive(3, 6, 1'b0);
    wait_drain();
    check("d1_idle_busy", busy[3], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
